// File: rtl/carry_path_pipe.sv
// carry_path_pipe: carry-in source select with optional CYI register, plus a
// CE-gated carry-out pipeline with a matching valid pipeline and a per-lane
// sticky carry flag. Lanes are fully independent bit slices.
//
// Qualifier semantics: VALID_IN travels alongside CARRYOUT through the same
// CE-gated stages, so VALID_OUT qualifies CARRYOUT_mux on the same cycle.
// There is no backpressure. A stage advances on every CLK edge where
// CECARRYIN=1 and holds otherwise. Data and valid are always captured
// together.
module carry_path_pipe #(
  parameter int    LANES      = 1,
  parameter int    CARRYINREG = 1,
  parameter int    DEPTH      = 1,
  parameter string CARRYINSEL = "OPMODE5",
  parameter int    STICKY_EN  = 1
) (
  input  logic             CLK,
  input  logic             RSTCARRYIN,
  input  logic             CECARRYIN,
  input  logic             OPMODE5,
  input  logic [LANES-1:0] CARRYIN,
  input  logic [LANES-1:0] CARRYOUT,
  input  logic             VALID_IN,
  input  logic             CLR_STICKY,
  output logic [LANES-1:0] CIN_mux,
  output logic [LANES-1:0] CARRYOUT_mux,
  output logic [LANES-1:0] CARRYOUTF,
  output logic             VALID_OUT,
  output logic [LANES-1:0] STICKY_CO
);

  // Elaboration-time guards on parameter values
  generate
    if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
      $error("carry_path_pipe: DEPTH must be 0..4");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
      $error("carry_path_pipe: LANES must be 1..8");
    end
    if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_sel
      $error("carry_path_pipe: CARRYINSEL must be OPMODE5 or CARRYIN");
    end
  endgenerate

  // Some inputs are structurally unused in certain parameterisations
  logic unused_inputs;
  assign unused_inputs = ^{OPMODE5, CARRYIN, CLR_STICKY, CECARRYIN};

  logic [LANES-1:0] cin_src;
  logic [LANES-1:0] co_out;
  logic             vld_out;

  // Carry-in source: the OPMODE5 bit broadcast to all lanes, or the per-lane port
  generate
    if (CARRYINSEL == "CARRYIN") begin : g_src_port
      assign cin_src = CARRYIN;
    end else begin : g_src_op
      assign cin_src = {LANES{OPMODE5}};
    end
  endgenerate

  generate
    if (CARRYINREG != 0) begin : g_cyi
      logic [LANES-1:0] cyi_d, cyi_q;

      // CYI register loads the selected source on CE-qualified edges
      always_comb begin
        cyi_d = cyi_q;
        if (CECARRYIN) cyi_d = cin_src;
      end

      // CYI state register, cleared asynchronously
      always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) cyi_q <= '0;
        else            cyi_q <= cyi_d;
      end

      assign CIN_mux = cyi_q;
    end else begin : g_cyi_bypass
      assign CIN_mux = cin_src;
    end
  endgenerate

  generate
    if (DEPTH > 0) begin : g_pipe
      logic [LANES-1:0] co_pipe_d [DEPTH];
      logic [LANES-1:0] co_pipe_q [DEPTH];
      logic [DEPTH-1:0] vld_pipe_d, vld_pipe_q;

      // All stages shift together on CE; otherwise every stage holds
      always_comb begin
        co_pipe_d  = co_pipe_q;
        vld_pipe_d = vld_pipe_q;
        if (CECARRYIN) begin
          co_pipe_d[0]  = CARRYOUT;
          vld_pipe_d[0] = VALID_IN;
          for (int k = 1; k < DEPTH; k++) begin
            co_pipe_d[k]  = co_pipe_q[k-1];
            vld_pipe_d[k] = vld_pipe_q[k-1];
          end
        end
      end

      // Pipeline registers; reset discards every in-flight carry and valid
      always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
          for (int k = 0; k < DEPTH; k++) co_pipe_q[k] <= '0;
          vld_pipe_q <= '0;
        end else begin
          co_pipe_q  <= co_pipe_d;
          vld_pipe_q <= vld_pipe_d;
        end
      end

      assign co_out  = co_pipe_q[DEPTH-1];
      assign vld_out = vld_pipe_q[DEPTH-1];
    end else begin : g_pipe_bypass
      assign co_out  = CARRYOUT;
      assign vld_out = VALID_IN;
    end
  endgenerate

  assign CARRYOUT_mux = co_out;
  assign CARRYOUTF    = co_out;
  assign VALID_OUT    = vld_out;

  generate
    if (STICKY_EN != 0) begin : g_sticky
      logic [LANES-1:0] sticky_d, sticky_q;

      // Clear first, then OR in a qualified carry so a coincident set wins
      always_comb begin
        sticky_d = (CLR_STICKY ? '0 : sticky_q) |
                   (co_out & {LANES{vld_out & CECARRYIN}});
      end

      // Sticky flag register, cleared asynchronously
      always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) sticky_q <= '0;
        else            sticky_q <= sticky_d;
      end

      assign STICKY_CO = sticky_q;
    end else begin : g_sticky_off
      assign STICKY_CO = '0;
    end
  endgenerate

endmodule

// File: tb/tb_carry_path_pipe.sv
// Bench for carry_path_pipe: three instances (DEPTH 2 / 3 / 0, different
// carry-in options) share one stimulus stream; a delay-queue reference model
// predicts each instance's outputs.
module tb_carry_path_pipe;
  localparam int L  = 2;
  localparam int DA = 2;
  localparam int DB = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic ce, op5, vin, clr;
  logic [L-1:0] cin, co;

  always #5 clk = ~clk;

  logic [L-1:0] cin_a, com_a, cof_a, st_a;
  logic [L-1:0] cin_b, com_b, cof_b, st_b;
  logic [L-1:0] cin_c, com_c, cof_c, st_c;
  logic         vo_a, vo_b, vo_c;

  carry_path_pipe #(.LANES(L), .CARRYINREG(1), .DEPTH(DA), .CARRYINSEL("CARRYIN"), .STICKY_EN(1)) dut_a (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .OPMODE5(op5), .CARRYIN(cin),
    .CARRYOUT(co), .VALID_IN(vin), .CLR_STICKY(clr), .CIN_mux(cin_a),
    .CARRYOUT_mux(com_a), .CARRYOUTF(cof_a), .VALID_OUT(vo_a), .STICKY_CO(st_a));

  carry_path_pipe #(.LANES(L), .CARRYINREG(1), .DEPTH(DB), .CARRYINSEL("OPMODE5"), .STICKY_EN(1)) dut_b (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .OPMODE5(op5), .CARRYIN(cin),
    .CARRYOUT(co), .VALID_IN(vin), .CLR_STICKY(clr), .CIN_mux(cin_b),
    .CARRYOUT_mux(com_b), .CARRYOUTF(cof_b), .VALID_OUT(vo_b), .STICKY_CO(st_b));

  carry_path_pipe #(.LANES(L), .CARRYINREG(0), .DEPTH(0), .CARRYINSEL("OPMODE5"), .STICKY_EN(1)) dut_c (
    .CLK(clk), .RSTCARRYIN(rst), .CECARRYIN(ce), .OPMODE5(op5), .CARRYIN(cin),
    .CARRYOUT(co), .VALID_IN(vin), .CLR_STICKY(clr), .CIN_mux(cin_c),
    .CARRYOUT_mux(com_c), .CARRYOUTF(cof_c), .VALID_OUT(vo_c), .STICKY_CO(st_c));

  // ---------------- scoreboard state ----------------
  // Each entry is {valid, carry}; a queue holds DEPTH entries ahead of the output.
  logic [L:0]   exp_a[$];
  logic [L:0]   exp_b[$];
  logic [L:0]   exp_c[$];
  logic [L-1:0] m_st_a, m_st_b, m_st_c, m_cin_a, m_cin_b;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void reset_model();
    exp_a.delete(); exp_b.delete(); exp_c.delete();
    repeat (DA) exp_a.push_back('0);
    repeat (DB) exp_b.push_back('0);
    m_st_a = '0; m_st_b = '0; m_st_c = '0;
    m_cin_a = '0; m_cin_b = '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic c_e, input logic v, input logic [L-1:0] co_v,
                       input logic [L-1:0] cin_v, input logic op, input logic clr_v);
    @(posedge clk); #1;
    ce = c_e; vin = v; co = co_v; cin = cin_v; op5 = op; clr = clr_v;
    if (c_e) begin
      exp_a.push_back({v, co_v});
      exp_b.push_back({v, co_v});
    end
    exp_c.push_back({v, co_v});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Reset pulse placed between clock edges; registered outputs must clear at once
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ce = 1'b0; vin = 1'b0; co = '0; cin = '0; op5 = 1'b0; clr = 1'b0;
    reset_model();
    #1;
    chk("rst_com_a", com_a, 0); chk("rst_cof_a", cof_a, 0); chk("rst_vo_a", vo_a, 0);
    chk("rst_st_a", st_a, 0);   chk("rst_cin_a", cin_a, 0);
    chk("rst_com_b", com_b, 0); chk("rst_vo_b", vo_b, 0);
    chk("rst_st_b", st_b, 0);   chk("rst_cin_b", cin_b, 0);
    chk("rst_st_c", st_c, 0);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  // Just before each edge: compare outputs with the model, then advance the model
  // for the edge that is about to happen.
  always @(negedge clk) begin
    logic [L:0] fa, fb, fc;
    if (!rst) begin
      if (exp_a.size() == 0 || exp_b.size() == 0 || exp_c.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL model_underflow: got empty queue expected entry at t=%0t", $time);
      end else begin
        fa = exp_a[0]; fb = exp_b[0]; fc = exp_c[0];
        chk("vo_a", vo_a, fa[L]);  chk("com_a", com_a, fa[L-1:0]); chk("cof_a", cof_a, fa[L-1:0]);
        chk("vo_b", vo_b, fb[L]);  chk("com_b", com_b, fb[L-1:0]); chk("cof_b", cof_b, fb[L-1:0]);
        chk("vo_c", vo_c, fc[L]);  chk("com_c", com_c, fc[L-1:0]); chk("cof_c", cof_c, fc[L-1:0]);
        chk("st_a", st_a, m_st_a); chk("st_b", st_b, m_st_b); chk("st_c", st_c, m_st_c);
        chk("cin_a", cin_a, m_cin_a); chk("cin_b", cin_b, m_cin_b);
        chk("cin_c", cin_c, {L{op5}});
        m_st_a = (clr ? '0 : m_st_a) | ((ce && fa[L]) ? fa[L-1:0] : '0);
        m_st_b = (clr ? '0 : m_st_b) | ((ce && fb[L]) ? fb[L-1:0] : '0);
        m_st_c = (clr ? '0 : m_st_c) | ((ce && fc[L]) ? fc[L-1:0] : '0);
        if (ce) begin
          m_cin_a = cin;
          m_cin_b = {L{op5}};
          void'(exp_a.pop_front());
          void'(exp_b.pop_front());
        end
        void'(exp_c.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ce = 1'b0; vin = 1'b0; co = '0; cin = '0; op5 = 1'b0; clr = 1'b0;
    reset_model();
    do_reset();

    // Two-sample sequence through the pipelines
    cycle(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'b10, 2'b11, 1'b1, 1'b0);
    idle(4);

    // Sticky: set once, coincident clear+carry on dut_a, then plain clear
    cycle(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    idle(3);
    cycle(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    idle(2);

    // CE held low for four cycles mid-stream; inputs during the stall are ignored
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 2'(i), 2'(i), i[0], 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 1'b1, 2'(3 - i), 2'(i), i[1], 1'b0);

    // Pipeline full of ones, then reset mid-stream and a fresh sample
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    idle(5);

    // Randomised traffic with CE gaps, clears and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    idle(6);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
